// File: rtl/avg_pool_pkg.sv
// Shared types and defaults for the average-pooling read sequencer.
// Holds the FSM state encoding and the packed-lane slicing helper.
package avg_pool_pkg;

  localparam int DEF_LANES  = 9;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_CH_W   = 4;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CLEAR   = 4'd1,
    ST_BUFFER  = 4'd2,
    ST_SETADDR = 4'd3,
    ST_WAIT    = 4'd4,
    ST_WRITE   = 4'd5,
    ST_UPDATE  = 4'd6,
    ST_NEXTCH  = 4'd7,
    ST_FINISH  = 4'd8
  } state_e;

  // Lowest bit of lane k inside a packed vector of width-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/avg_lane_addr_gen.sv
// Combinational address/mask generator for one group of parallel read lanes.
// Outputs are forced to zero when the sequencer is not in an address phase.
module avg_lane_addr_gen
  import avg_pool_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    en_i,
  input  logic [ADDR_W-1:0]       base_i,
  input  logic [ADDR_W:0]         offset_i,
  input  logic [ADDR_W-1:0]       len_i,
  output logic [LANES*ADDR_W-1:0] addr_o,
  output logic [LANES-1:0]        mask_o
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int            LSB      = lane_lsb(k, ADDR_W);
    localparam logic [ADDR_W:0] LANE_OFF = (ADDR_W+1)'(k);
    logic [ADDR_W:0] lane_off;

    // One extra bit keeps offset+k < len from wrapping near the top of the range.
    assign lane_off = offset_i + LANE_OFF;
    assign addr_o[LSB +: ADDR_W] = en_i ? (base_i + lane_off[ADDR_W-1:0]) : '0;
    assign mask_o[k] = en_i && (lane_off < {1'b0, len_i});
  end

endmodule

// File: rtl/avg_pool_sequencer.sv
// Walks numCh channels of len words in groups of LANES, launching RAM reads
// and strobing the averaging accumulator; FSM state is exported on o_dbgState.
//
// Handshake: o_startRam is a one-cycle launch; the sequencer then waits in WAIT
// until i_validRam is sampled high, and i_validRam is ignored in all other states.
module avg_pool_sequencer
  import avg_pool_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [ADDR_W-1:0]       i_len,
  input  logic [CH_W-1:0]         i_numCh,
  input  logic [ADDR_W-1:0]       i_chStride,
  input  logic                    i_validRam,
  output logic [LANES*ADDR_W-1:0] o_addrRead,
  output logic [LANES-1:0]        o_laneMask,
  output logic                    o_startRam,
  output logic                    o_writeEnable,
  output logic                    o_resetAverage,
  output logic                    o_chDone,
  output logic [CH_W-1:0]         o_chIdx,
  output logic                    o_busy,
  output logic                    o_finish,
  output logic [3:0]              o_dbgState
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] len_q, stride_q, base_q;
  logic [ADDR_W:0]   offset_q;
  logic [CH_W-1:0]   num_ch_q, ch_q;

  logic start_ram_q, write_en_q, reset_avg_q, ch_done_q, busy_q, finish_q;

  logic [ADDR_W:0] offset_d;
  logic [CH_W:0]   ch_d;
  logic            addr_en;

  assign offset_d = offset_q + (ADDR_W+1)'(LANES);
  assign ch_d     = {1'b0, ch_q} + (CH_W+1)'(1);
  assign addr_en  = (state_q == ST_SETADDR) || (state_q == ST_WAIT) || (state_q == ST_WRITE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if ((i_len == '0) || (i_numCh == '0)) state_d = ST_FINISH;
          else                                  state_d = ST_CLEAR;
        end
      end
      ST_CLEAR:   state_d = ST_BUFFER;
      ST_BUFFER:  state_d = ST_SETADDR;
      ST_SETADDR: state_d = ST_WAIT;
      ST_WAIT:    if (i_validRam) state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_UPDATE;
      ST_UPDATE:  state_d = (offset_d >= {1'b0, len_q}) ? ST_NEXTCH : ST_SETADDR;
      ST_NEXTCH:  state_d = (ch_d == {1'b0, num_ch_q}) ? ST_FINISH : ST_CLEAR;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Abort wins over everything else, including a valid arriving in WAIT.
    if ((state_q != ST_IDLE) && i_abort) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      stride_q    <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      num_ch_q    <= '0;
      ch_q        <= '0;
      start_ram_q <= 1'b0;
      write_en_q  <= 1'b0;
      reset_avg_q <= 1'b1;
      ch_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Strobes are registered from the next state so they align with it.
      start_ram_q <= (state_d == ST_SETADDR);
      write_en_q  <= (state_d == ST_WRITE);
      reset_avg_q <= (state_d != ST_CLEAR);
      ch_done_q   <= (state_d == ST_NEXTCH);
      busy_q      <= (state_d != ST_IDLE);
      finish_q    <= (state_d == ST_FINISH);

      if ((state_q == ST_IDLE) && i_start) begin
        len_q    <= i_len;
        num_ch_q <= i_numCh;
        stride_q <= i_chStride;
        base_q   <= '0;
        offset_q <= '0;
        ch_q     <= '0;
      end

      if (state_q == ST_UPDATE) offset_q <= offset_d;

      if (state_q == ST_NEXTCH) begin
        base_q   <= base_q + stride_q;
        ch_q     <= ch_d[CH_W-1:0];
        offset_q <= '0;
      end
    end
  end

  avg_lane_addr_gen #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .en_i     (addr_en),
    .base_i   (base_q),
    .offset_i (offset_q),
    .len_i    (len_q),
    .addr_o   (o_addrRead),
    .mask_o   (o_laneMask)
  );

  assign o_startRam     = start_ram_q;
  assign o_writeEnable  = write_en_q;
  assign o_resetAverage = reset_avg_q;
  assign o_chDone       = ch_done_q;
  assign o_chIdx        = ch_q;
  assign o_busy         = busy_q;
  assign o_finish       = finish_q;
  assign o_dbgState     = state_q;

endmodule

// File: tb/tb_avg_pool_sequencer.sv
// Directed bench for avg_pool_sequencer: expected groups are queued at start
// and popped as each read launch appears.
module tb_avg_pool_sequencer;

  localparam int LANES  = 9;
  localparam int ADDR_W = 12;
  localparam int CH_W   = 4;
  localparam int EW     = LANES*ADDR_W + LANES + CH_W;

  logic                    clk;
  logic                    i_reset, i_start, i_abort, i_validRam;
  logic [ADDR_W-1:0]       i_len, i_chStride;
  logic [CH_W-1:0]         i_numCh;
  logic [LANES*ADDR_W-1:0] o_addrRead;
  logic [LANES-1:0]        o_laneMask;
  logic                    o_startRam, o_writeEnable, o_resetAverage, o_chDone;
  logic                    o_busy, o_finish;
  logic [CH_W-1:0]         o_chIdx;
  logic [3:0]              o_dbgState;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  avg_pool_sequencer #(.LANES(LANES), .ADDR_W(ADDR_W), .CH_W(CH_W)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_len          (i_len),
    .i_numCh        (i_numCh),
    .i_chStride     (i_chStride),
    .i_validRam     (i_validRam),
    .o_addrRead     (o_addrRead),
    .o_laneMask     (o_laneMask),
    .o_startRam     (o_startRam),
    .o_writeEnable  (o_writeEnable),
    .o_resetAverage (o_resetAverage),
    .o_chDone       (o_chDone),
    .o_chIdx        (o_chIdx),
    .o_busy         (o_busy),
    .o_finish       (o_finish),
    .o_dbgState     (o_dbgState)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  128'(o_addrRead), 128'(0));
    check({tag, "_mask"},  128'(o_laneMask), 128'(0));
    check({tag, "_ctl"},   128'({o_startRam, o_writeEnable, o_resetAverage, o_chDone, o_busy, o_finish}),
          128'(6'b001000));
    check({tag, "_chidx"}, 128'(o_chIdx), 128'(0));
  endtask

  // Reference model: every group of every channel, in issue order.
  task automatic push_expected(input logic [11:0] len, input logic [3:0] nch, input logic [11:0] stride);
    logic [11:0] base, a;
    logic [LANES*ADDR_W-1:0] av;
    logic [LANES-1:0] mv;
    base = '0;
    for (int c = 0; c < int'(nch); c++) begin
      for (int off = 0; off < int'(len); off += LANES) begin
        for (int k = 0; k < LANES; k++) begin
          a = base + 12'(off + k);
          av[k*ADDR_W +: ADDR_W] = a;
          mv[k] = ((off + k) < int'(len));
        end
        exp_q.push_back({av, mv, 4'(c)});
      end
      base = base + stride;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [11:0] len, input logic [3:0] nch, input logic [11:0] stride,
                        input int vdelay, input string tag);
    int cyc, vcnt, n_sr, n_we, n_clr, n_done, n_busy, first_sr, fin_cyc, groups, nch_eff, exp_fin;
    logic [3:0] fin_ch;
    logic [EW-1:0] cur;
    nch_eff = (len == 0 || nch == 0) ? 0 : int'(nch);
    groups  = nch_eff * ((int'(len) + LANES - 1) / LANES);
    exp_fin = (groups == 0) ? 1
            : 1 + nch_eff * (3 + ((int'(len) + LANES - 1) / LANES) * (3 + ((vdelay < 1) ? 1 : vdelay)));
    push_expected(len, nch, stride);
    n_sr = 0; n_we = 0; n_clr = 0; n_done = 0; n_busy = 0;
    first_sr = -1; fin_cyc = -1; vcnt = -1; fin_ch = '0; cur = '0;
    i_len = len; i_numCh = nch; i_chStride = stride; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    while (cyc <= 3000) begin
      if (o_busy) n_busy++;
      if (o_startRam) begin
        n_sr++;
        if (first_sr < 0) first_sr = cyc;
        if (exp_q.size() == 0) check({tag, "_extra_group"}, 128'(exp_q.size()), 128'(1));
        else begin
          cur = exp_q.pop_front();
          check({tag, "_group"}, 128'({o_addrRead, o_laneMask, o_chIdx}), 128'(cur));
        end
        vcnt = vdelay;
      end
      if (o_writeEnable) begin
        n_we++;
        check({tag, "_hold"}, 128'({o_addrRead, o_laneMask, o_chIdx}), 128'(cur));
        i_validRam = 1'b0;
      end
      if (!o_resetAverage) n_clr++;
      if (o_chDone) n_done++;
      if (o_finish) begin
        fin_cyc = cyc;
        fin_ch  = o_chIdx;
        break;
      end
      if (vcnt == 0) i_validRam = 1'b1;
      if (vcnt >= 0) vcnt--;
      @(negedge clk);
      cyc++;
    end
    i_validRam = 1'b0;
    check({tag, "_finish_cycle"}, 128'(fin_cyc), 128'(exp_fin));
    if (groups > 0) check({tag, "_first_startram"}, 128'(first_sr), 128'(3));
    check({tag, "_startram_cnt"}, 128'(n_sr), 128'(groups));
    check({tag, "_write_cnt"},    128'(n_we), 128'(groups));
    check({tag, "_clear_cnt"},    128'(n_clr), 128'(nch_eff));
    check({tag, "_chdone_cnt"},   128'(n_done), 128'(nch_eff));
    check({tag, "_busy_cycles"},  128'(n_busy), 128'(exp_fin));
    check({tag, "_chidx_fin"},    128'(fin_ch), 128'(nch_eff));
    check({tag, "_queue_left"},   128'(exp_q.size()), 128'(0));
    exp_q.delete();
    @(negedge clk);
    check({tag, "_idle_after"}, 128'({o_busy, o_finish}), 128'(0));
  endtask

  task automatic wait_for_startram(input string tag);
    int n;
    n = 0;
    while (!o_startRam && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_startram_seen"}, 128'(o_startRam), 128'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int fin_seen;
    i_reset = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_validRam = 1'b0;
    i_len = '0; i_numCh = '0; i_chStride = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_state", 128'(o_dbgState), 128'(0));
    i_reset = 1'b1;
    @(negedge clk);

    run_op(12'd18,   4'd1,  12'd0,    2, "len18");
    run_op(12'd20,   4'd1,  12'd0,    2, "len20");
    run_op(12'd9,    4'd3,  12'd100,  1, "three_ch");
    run_op(12'd9,    4'd2,  12'd4090, 2, "wrap");
    run_op(12'd18,   4'd1,  12'd0,    0, "min_group");
    run_op(12'd0,    4'd1,  12'd5,    2, "len0");
    run_op(12'd7,    4'd0,  12'd5,    2, "nch0");
    run_op(12'd10,   4'd15, 12'd300,  0, "max_ch");
    run_op(12'd4095, 4'd1,  12'd0,    0, "max_len");

    // Abort in WAIT with valid high on the same edge.
    i_len = 12'd18; i_numCh = 4'd1; i_chStride = '0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_for_startram("abort");
    check("abort_lane0", 128'({o_addrRead[ADDR_W-1:0], o_laneMask}), 128'({12'd0, 9'h1ff}));
    @(negedge clk);
    check("abort_in_wait", 128'(o_dbgState), 128'(4));
    i_abort = 1'b1; i_validRam = 1'b1;
    @(negedge clk);
    i_abort = 1'b0; i_validRam = 1'b0;
    check("abort_idle", 128'({o_busy, o_writeEnable, o_finish, o_chDone}), 128'(0));
    check("abort_addr", 128'({o_addrRead, o_laneMask}), 128'(0));
    fin_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_finish || o_writeEnable || o_busy) fin_seen++;
    end
    check("abort_quiet", 128'(fin_seen), 128'(0));
    run_op(12'd9, 4'd1, 12'd0, 2, "after_abort");

    // Reset asserted while in WRITE.
    i_len = 12'd9; i_numCh = 4'd1; i_chStride = '0; i_start = 1'b1; i_validRam = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    fin_seen = 0;
    while (!o_writeEnable && fin_seen < 50) begin
      @(negedge clk);
      fin_seen++;
    end
    check("rst_write_seen", 128'(o_writeEnable), 128'(1));
    i_reset = 1'b0;
    @(negedge clk);
    i_reset = 1'b1; i_validRam = 1'b0;
    check_reset_outputs("rst_mid");
    check("rst_mid_state", 128'(o_dbgState), 128'(0));
    @(negedge clk);
    run_op(12'd20, 4'd2, 12'd50, 1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_pool_sequencer.md
# avg_pool_sequencer

Parametrised control sequencer for the average-pooling stage. It walks one or more channels of a feature buffer in groups of `LANES` consecutive words. For each group it drives a packed address vector and a per-lane valid mask, launches a RAM read, waits for read data, and strobes the accumulator write. It clears the accumulator at the start of each channel and flags channel completion. It sits between the layer scheduler (start/finish) and the multi-port feature RAM plus the averaging datapath.

## Interface
- `LANES`, 9, read lanes per group (addresses issued in parallel)
- `ADDR_W`, 12, RAM word-address width
- `CH_W`, 4, channel-count and channel-index width
- `i_clk`  in  1  clock
- `i_reset`  in  1  reset; one clock, synchronous, active-low
- `i_start`  in  1  start request; sampled only in IDLE
- `i_abort`  in  1  abandon the current operation
- `i_len`  in  ADDR_W  words per channel; latched at start
- `i_numCh`  in  CH_W  number of channels; latched at start
- `i_chStride`  in  ADDR_W  base-address step between channels; latched at start
- `i_validRam`  in  1  RAM read data valid
- `o_addrRead`  out  LANES*ADDR_W  packed addresses; lane k occupies bits [k*ADDR_W +: ADDR_W]
- `o_laneMask`  out  LANES  per-lane valid mask
- `o_startRam`  out  1  one-cycle read launch
- `o_writeEnable`  out  1  one-cycle accumulate strobe
- `o_resetAverage`  out  1  accumulator clear, active-low
- `o_chDone`  out  1  one-cycle pulse; channel average complete
- `o_chIdx`  out  CH_W  current channel index
- `o_busy`  out  1  high in every state except IDLE
- `o_finish`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLEAR, BUFFER, SETADDR, WAIT, WRITE, UPDATE, NEXTCH, FINISH.
- IDLE: on `i_start`, latch len/numCh/stride and clear base, offset and chIdx.
  - If len==0 or numCh==0, go to FINISH (no RAM access).
  - Otherwise go to CLEAR.
- CLEAR: `o_resetAverage`=0 for one cycle, then BUFFER.
- BUFFER: one idle cycle, then SETADDR.
- SETADDR: `o_startRam`=1, then WAIT.
- WAIT: hold until `i_validRam`, then WRITE. `i_validRam` is ignored in every other state.
- WRITE: `o_writeEnable`=1, then UPDATE.
- UPDATE: offset += LANES.
  - If the new offset is >= len, go to NEXTCH.
  - Otherwise go to SETADDR.
- NEXTCH: `o_chDone`=1; base += stride; chIdx += 1; offset cleared.
  - If the new chIdx == numCh, go to FINISH.
  - Otherwise go to CLEAR.
- FINISH: `o_finish`=1 for one cycle, then IDLE.
- Address generation in SETADDR, WAIT and WRITE:
  - lane k = (base + offset + k) mod 2^ADDR_W; wrap-around is silent.
  - mask[k] = (offset + k < len), computed with ADDR_W+1 bits so the comparison cannot overflow.
- In every other state, addresses and mask are 0.
- Groups per channel = ceil(len/LANES). The last group carries a partial mask when len is not a multiple of LANES.
- `i_abort` in any non-IDLE state forces IDLE on the next edge. It has priority over `i_validRam`. No `o_finish` or `o_chDone` is issued.
- `i_start` while busy is ignored.
- `i_numCh` = 2^CH_W−1 is the maximum; chIdx must not overflow.

## Timing
- Reset (`i_reset`=0 at an edge) forces IDLE from any state, including mid-operation. Output values after reset:
  - all outputs 0, except `o_resetAverage`=1
  - `o_chIdx`=0
- Outputs are combinational from state and registers; no output depends combinationally on inputs.
- Start to first `o_startRam`: `i_start` sampled at edge 0 gives CLEAR in cycle 1, BUFFER in cycle 2, SETADDR (`o_startRam`) in cycle 3.
- Minimum group time is 4 cycles (SETADDR, WAIT with valid already high, WRITE, UPDATE).
- Addresses and mask are stable from SETADDR through WRITE.
- len==0 or numCh==0: `o_finish` in cycle 1 after start; `o_busy` high for that one cycle only.

## Structure
- Package `avg_pool_pkg` holds:
  - the state enum
  - default `LANES`/`ADDR_W`/`CH_W` constants
  - the lane-slice helper function
- Sub-module `avg_lane_addr_gen` (combinational): takes base, offset and len; produces the packed addresses and mask.
- The FSM and counters live in the top module.

## Test plan
- len=18, numCh=1, stride=0, valid 2 cycles after each `o_startRam` -> groups at 0..8 and 9..17, mask all ones, one `o_chDone`, then `o_finish`.
- len=20 -> 3 groups; third group addresses 18..26 with mask 9'b000000011.
- numCh=3, stride=100, len=9 -> bases 0, 100, 200; three `o_resetAverage` low pulses, three `o_chDone`, `o_chIdx` 0→1→2.
- numCh=2, stride=4090, len=9 -> channel 1 addresses 4090..4095 then 0..2, mask all ones.
- `i_abort` in WAIT with `i_validRam` high in the same cycle -> IDLE next cycle, no `o_writeEnable`, no `o_finish`; `i_start` then works normally.
- len=0 -> `o_finish` one cycle after start, no `o_startRam`. Separately, `i_reset`=0 during WRITE -> IDLE with reset output values on the next edge.
